bn_res_out_packer: RTL and testbench

Output stage behind the batch-norm/residual block. Accepts one full-width vector of CHANNEL_NUM signed DATA_WIDTH results per `data_in_valid` and requantizes each channel to signed OUT_WIDTH: rounding arithmetic right shift, optional ReLU, then saturation. It then serializes the vector as CHANNEL_NUM/LANES beats on a valid/ready stream, which feeds the next layer's 8-bit activation input. Upstream has no backpressure, so a vector arriving while the block is busy is dropped and flagged.

---
 rtl/bn_res_out_packer.sv | 200 ++++++++++++++++++++
 tb/tb_bn_res_out_packer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bn_res_out_packer.sv
// bn_res_out_packer
//
// Output stage behind the batch-norm/residual block. A full vector of
// CHANNEL_NUM signed DATA_WIDTH results is captured in one cycle and
// requantized per channel to signed OUT_WIDTH (rounding arithmetic right
// shift, optional ReLU, saturation). The vector is then streamed out as
// NG = CHANNEL_NUM/LANES beats on a valid/ready interface. Upstream cannot
// stall, so a vector that arrives while a burst is still in flight is
// discarded and the sticky overrun flag is raised.
//
// Ports
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset
//   data_in_valid  single-cycle strobe for an input vector
//   data_in        CHANNEL_NUM x DATA_WIDTH signed, channel c at index c
//   data_in_ready  vector accepted this cycle if data_in_valid is high
//   shift          right-shift amount, captured on accept
//   relu_en        clamp negatives to zero, captured on accept
//   out_valid      an output beat is present
//   out_ready      downstream accepts the beat
//   out_data       LANES x OUT_WIDTH signed, lane l of group g = channel g*LANES+l
//   out_group      beat index within the vector
//   out_last       high on the final beat (group NG-1)
//   overrun        sticky, set when an input vector is dropped

module bn_res_out_packer #(
    parameter int DATA_WIDTH  = 16,
    parameter int CHANNEL_NUM = 128,
    parameter int OUT_WIDTH   = 8,
    parameter int LANES       = 16,
    parameter int SHIFT_WIDTH = 4,
    localparam int NG = CHANNEL_NUM / LANES,
    localparam int GW = (NG > 1) ? $clog2(NG) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    data_in_valid,
    input  logic [CHANNEL_NUM-1:0][DATA_WIDTH-1:0]  data_in,
    output logic                                    data_in_ready,
    input  logic [SHIFT_WIDTH-1:0]                  shift,
    input  logic                                    relu_en,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [LANES-1:0][OUT_WIDTH-1:0]         out_data,
    output logic [GW-1:0]                           out_group,
    output logic                                    out_last,
    output logic                                    overrun
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [GW-1:0] LAST_GROUP = GW'(NG - 1);

    // Saturation bounds expressed at the widened intermediate width so the
    // comparisons below stay signed and width-matched.
    localparam logic signed [DATA_WIDTH:0] SAT_MAX = (DATA_WIDTH + 1)'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [DATA_WIDTH:0] SAT_MIN = (DATA_WIDTH + 1)'(-(2 ** (OUT_WIDTH - 1)));

    state_t state;
    state_t state_next;
    logic [GW-1:0] group;
    logic [GW-1:0] group_next;

    // Holding register viewed as [group][lane] so the current beat is a
    // plain index by the group counter.
    logic [NG-1:0][LANES-1:0][DATA_WIDTH-1:0] hold_data;
    logic [SHIFT_WIDTH-1:0]                   hold_shift;
    logic                                     hold_relu;

    logic [LANES-1:0][DATA_WIDTH-1:0] cur_group;
    logic signed [DATA_WIDTH:0]       round_bias;

    logic accept;
    logic handshake;
    logic at_last;

    assign at_last   = (group == LAST_GROUP);
    assign out_valid = (state == SEND);
    assign out_last  = out_valid && at_last;
    assign out_group = group;
    assign handshake = out_valid && out_ready;

    // Ready is combinational from out_ready so a new vector can be taken on
    // the same edge that retires the final beat, giving bubble-free bursts.
    // Reset holds it low so nothing can be accepted while rst is asserted.
    assign data_in_ready = !rst && ((state == IDLE) || (out_last && out_ready));
    assign accept        = data_in_valid && data_in_ready;

    // State and beat counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            group <= '0;
        end else begin
            state <= state_next;
            group <= group_next;
        end
    end

    // Next-state logic. An accept always restarts at group 0; in SEND it can
    // only coincide with the final handshake, so it overrides the return to
    // IDLE. The counter is explicitly cleared when a burst ends so out_group
    // reads 0 whenever the block is idle.
    always_comb begin
        state_next = state;
        group_next = group;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SEND;
                    group_next = '0;
                end
            end
            SEND: begin
                if (accept) begin
                    state_next = SEND;
                    group_next = '0;
                end else if (handshake) begin
                    if (at_last) begin
                        state_next = IDLE;
                        group_next = '0;
                    end else begin
                        group_next = group + GW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                group_next = '0;
            end
        endcase
    end

    // Capture the vector and its quantization controls on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data  <= '0;
            hold_shift <= '0;
            hold_relu  <= 1'b0;
        end else if (accept) begin
            hold_data  <= data_in;
            hold_shift <= shift;
            hold_relu  <= relu_en;
        end
    end

    // A vector offered while not ready is lost; remember that until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (data_in_valid && !data_in_ready) begin
            overrun <= 1'b1;
        end
    end

    assign cur_group = hold_data[group];

    // Half of one output LSB, added before the shift so that truncation
    // toward -inf becomes round-half-toward-+inf.
    always_comb begin
        round_bias = '0;
        if (hold_shift != '0) begin
            round_bias = (DATA_WIDTH + 1)'(1) << (hold_shift - SHIFT_WIDTH'(1));
        end
    end

    // Per-lane requantization. One extra bit of headroom keeps the rounding
    // add from overflowing for the largest positive input.
    always_comb begin
        logic signed [DATA_WIDTH:0] ext;
        logic signed [DATA_WIDTH:0] biased;
        logic signed [DATA_WIDTH:0] shifted;
        logic signed [DATA_WIDTH:0] clipped;
        out_data = '0;
        ext      = '0;
        biased   = '0;
        shifted  = '0;
        clipped  = '0;
        for (int l = 0; l < LANES; l++) begin
            ext     = {cur_group[l][DATA_WIDTH-1], cur_group[l]};
            biased  = ext + round_bias;
            shifted = (hold_shift == '0) ? ext : (biased >>> hold_shift);
            clipped = shifted;
            if (hold_relu && (shifted < 0)) begin
                clipped = '0;
            end
            if (clipped > SAT_MAX) begin
                out_data[l] = SAT_MAX[OUT_WIDTH-1:0];
            end else if (clipped < SAT_MIN) begin
                out_data[l] = SAT_MIN[OUT_WIDTH-1:0];
            end else begin
                out_data[l] = clipped[OUT_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_bn_res_out_packer.sv
// Testbench for bn_res_out_packer.
//
// A behavioural model tracks, per input vector, the list of quantized
// channel values (computed with real arithmetic from the rounding rule) and
// which beat of the burst is on the bus. Every cycle the DUT outputs are
// compared against it at the falling edge; directed scenarios add literal,
// hand-computed expectations, and a randomized phase follows.

module tb_bn_res_out_packer;

    localparam int DATA_WIDTH  = 16;
    localparam int CHANNEL_NUM = 128;
    localparam int OUT_WIDTH   = 8;
    localparam int LANES       = 16;
    localparam int SHIFT_WIDTH = 4;
    localparam int NG          = CHANNEL_NUM / LANES;
    localparam int GW          = (NG > 1) ? $clog2(NG) : 1;
    localparam int QMAX        = (2 ** (OUT_WIDTH - 1)) - 1;
    localparam int QMIN        = -(2 ** (OUT_WIDTH - 1));

    typedef logic [CHANNEL_NUM-1:0][DATA_WIDTH-1:0] vec_t;
    typedef logic [LANES*OUT_WIDTH-1:0]             beat_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   data_in_valid;
    vec_t                   data_in;
    logic                   data_in_ready;
    logic [SHIFT_WIDTH-1:0] shift;
    logic                   relu_en;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES-1:0][OUT_WIDTH-1:0] out_data;
    logic [GW-1:0]          out_group;
    logic                   out_last;
    logic                   overrun;

    // Model state
    bit m_busy    = 1'b0;
    int m_beat    = 0;
    bit m_overrun = 1'b0;
    int m_q [CHANNEL_NUM];

    int tests       = 0;
    int fails       = 0;
    int beats_total = 0;

    bn_res_out_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .CHANNEL_NUM(CHANNEL_NUM),
        .OUT_WIDTH  (OUT_WIDTH),
        .LANES      (LANES),
        .SHIFT_WIDTH(SHIFT_WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in_valid(data_in_valid),
        .data_in      (data_in),
        .data_in_ready(data_in_ready),
        .shift        (shift),
        .relu_en      (relu_en),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_group    (out_group),
        .out_last     (out_last),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Requantization straight from the arithmetic definition: x / 2^s rounded
    // half toward +inf, optional ReLU, then clamp to the output range.
    function automatic int quant(int x, int s, bit relu);
        real r;
        int  y;
        r = $floor((real'(x) / (2.0 ** s)) + 0.5);
        y = $rtoi(r);
        if (relu && (y < 0)) y = 0;
        if (y > QMAX) y = QMAX;
        if (y < QMIN) y = QMIN;
        return y;
    endfunction

    function automatic bit modelReady();
        return !rst && (!m_busy || ((m_beat == NG - 1) && out_ready));
    endfunction

    function automatic beat_t modelBeat();
        beat_t v;
        v = '0;
        for (int l = 0; l < LANES; l++) begin
            v[l*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(m_q[m_beat*LANES + l]);
        end
        return v;
    endfunction

    function automatic beat_t rampBeat(int base, int step);
        beat_t v;
        v = '0;
        for (int l = 0; l < LANES; l++) begin
            v[l*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(base + step * l);
        end
        return v;
    endfunction

    function automatic vec_t rampVec(int step);
        vec_t v;
        for (int c = 0; c < CHANNEL_NUM; c++) begin
            v[c] = DATA_WIDTH'(step * c);
        end
        return v;
    endfunction

    function automatic vec_t randomVec();
        vec_t v;
        for (int c = 0; c < CHANNEL_NUM; c++) begin
            if ($urandom_range(1) == 0) begin
                v[c] = DATA_WIDTH'($urandom);
            end else begin
                v[c] = DATA_WIDTH'(int'($urandom_range(2047)) - 1024);
            end
        end
        return v;
    endfunction

    // Model update: the burst advances on each handshake, a vector is taken
    // whenever it is offered while ready, and otherwise it is dropped.
    always @(posedge clk) begin
        if (rst) begin
            m_busy    <= 1'b0;
            m_beat    <= 0;
            m_overrun <= 1'b0;
            for (int c = 0; c < CHANNEL_NUM; c++) m_q[c] <= 0;
        end else begin
            if (data_in_valid && !modelReady()) begin
                m_overrun <= 1'b1;
            end
            if (data_in_valid && modelReady()) begin
                for (int c = 0; c < CHANNEL_NUM; c++) begin
                    m_q[c] <= quant($signed(data_in[c]), int'(shift), relu_en);
                end
                m_busy <= 1'b1;
                m_beat <= 0;
            end else if (m_busy && out_ready) begin
                if (m_beat == NG - 1) begin
                    m_busy <= 1'b0;
                    m_beat <= 0;
                end else begin
                    m_beat <= m_beat + 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) beats_total <= beats_total + 1;
    end

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compareModel();
        checkOutput("out_valid", 256'(out_valid), 256'(m_busy));
        checkOutput("data_in_ready", 256'(data_in_ready), 256'(modelReady()));
        checkOutput("overrun", 256'(overrun), 256'(m_overrun));
        if (m_busy) begin
            checkOutput("out_data", 256'(out_data), 256'(modelBeat()));
            checkOutput("out_group", 256'(out_group), 256'(m_beat));
            checkOutput("out_last", 256'(out_last), 256'(m_beat == NG - 1));
        end
    endtask

    // Advance to the next falling edge and compare against the model.
    task automatic cycle();
        @(negedge clk);
        compareModel();
    endtask

    // Offer one vector for a single cycle; returns at the falling edge of the
    // cycle after the accepting edge.
    task automatic applyStimulus(input vec_t vec, input logic [SHIFT_WIDTH-1:0] sh, input bit relu);
        data_in       = vec;
        shift         = sh;
        relu_en       = relu;
        data_in_valid = 1'b1;
        cycle();
        data_in_valid = 1'b0;
    endtask

    task automatic waitIdle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            cycle();
            if (!out_valid) done = 1'b1;
        end
        checkOutput("idle_timeout", 256'(done), 256'(1));
    endtask

    initial begin
        int   start_beats;
        vec_t v;

        rst           = 1'b1;
        data_in_valid = 1'b0;
        data_in       = '0;
        shift         = '0;
        relu_en       = 1'b0;
        out_ready     = 1'b1;

        // Reset state
        cycle();
        checkOutput("rst_valid", 256'(out_valid), 256'(0));
        checkOutput("rst_ready", 256'(data_in_ready), 256'(0));
        checkOutput("rst_group", 256'(out_group), 256'(0));
        checkOutput("rst_last", 256'(out_last), 256'(0));
        checkOutput("rst_overrun", 256'(overrun), 256'(0));
        checkOutput("rst_data", 256'(out_data), 256'(0));
        cycle();
        rst = 1'b0;
        cycle();
        checkOutput("post_rst_ready", 256'(data_in_ready), 256'(1));

        // Basic burst: channel c carries c, shift 0
        start_beats = beats_total;
        applyStimulus(rampVec(1), '0, 1'b0);
        for (int g = 0; g < NG; g++) begin
            if (g > 0) cycle();
            checkOutput("basic_data", 256'(out_data), 256'(rampBeat(16 * g, 1)));
            checkOutput("basic_group", 256'(out_group), 256'(g));
            checkOutput("basic_last", 256'(out_last), 256'(g == NG - 1));
        end
        cycle();
        checkOutput("basic_end_valid", 256'(out_valid), 256'(0));
        checkOutput("basic_end_ready", 256'(data_in_ready), 256'(1));
        checkOutput("basic_beats", 256'(beats_total - start_beats), 256'(NG));

        // Round / saturate, without and with ReLU
        v = randomVec();
        v[0] = 16'd5;
        v[1] = 16'd6;
        v[2] = 16'hFFFA;
        v[3] = 16'hFFF9;
        v[4] = 16'h7FFF;
        v[5] = 16'h8000;
        applyStimulus(v, SHIFT_WIDTH'(2), 1'b0);
        checkOutput("round_sat", 256'(out_data[5:0]), 256'(48'h807FFEFF0201));
        waitIdle();
        applyStimulus(v, SHIFT_WIDTH'(2), 1'b1);
        checkOutput("round_sat_relu", 256'(out_data[5:0]), 256'(48'h007F00000201));
        waitIdle();

        // Backpressure on group 3 for three cycles
        start_beats = beats_total;
        applyStimulus(rampVec(1), '0, 1'b0);
        repeat (3) cycle();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checkOutput("stall_valid", 256'(out_valid), 256'(1));
            checkOutput("stall_data", 256'(out_data), 256'(rampBeat(48, 1)));
            checkOutput("stall_group", 256'(out_group), 256'(3));
            checkOutput("stall_last", 256'(out_last), 256'(0));
        end
        out_ready = 1'b1;
        waitIdle();
        checkOutput("stall_beats", 256'(beats_total - start_beats), 256'(NG));

        // Back-to-back: second vector offered during the group-7 handshake
        applyStimulus(rampVec(1), '0, 1'b0);
        repeat (NG - 1) cycle();
        applyStimulus(rampVec(-1), '0, 1'b0);
        checkOutput("b2b_valid", 256'(out_valid), 256'(1));
        checkOutput("b2b_group", 256'(out_group), 256'(0));
        checkOutput("b2b_data", 256'(out_data), 256'(rampBeat(0, -1)));
        checkOutput("b2b_overrun", 256'(overrun), 256'(0));
        waitIdle();

        // Overrun: vector offered while group 2 is presented
        applyStimulus(rampVec(1), '0, 1'b0);
        repeat (2) cycle();
        applyStimulus(rampVec(3), '0, 1'b0);
        checkOutput("ovr_flag", 256'(overrun), 256'(1));
        checkOutput("ovr_group", 256'(out_group), 256'(3));
        checkOutput("ovr_data", 256'(out_data), 256'(rampBeat(48, 1)));
        waitIdle();
        repeat (3) cycle();
        checkOutput("ovr_no_extra", 256'(out_valid), 256'(0));
        checkOutput("ovr_sticky", 256'(overrun), 256'(1));

        // Reset mid-burst at group 4
        applyStimulus(rampVec(1), '0, 1'b0);
        repeat (4) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checkOutput("midrst_valid", 256'(out_valid), 256'(0));
        checkOutput("midrst_overrun", 256'(overrun), 256'(0));
        checkOutput("midrst_group", 256'(out_group), 256'(0));
        start_beats = beats_total;
        applyStimulus(rampVec(-1), '0, 1'b0);
        waitIdle();
        checkOutput("midrst_beats", 256'(beats_total - start_beats), 256'(NG));

        // Randomized traffic with random backpressure and arrivals
        for (int k = 0; k < 600; k++) begin
            cycle();
            out_ready = ($urandom_range(3) != 0);
            if ($urandom_range(9) == 0) begin
                data_in       = randomVec();
                shift         = SHIFT_WIDTH'($urandom);
                relu_en       = 1'($urandom_range(1));
                data_in_valid = 1'b1;
            end else begin
                data_in_valid = 1'b0;
            end
        end
        cycle();
        data_in_valid = 1'b0;
        out_ready     = 1'b1;
        waitIdle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
